// File: rtl/shift_tx_pkg.sv
// Shared types and constants for the shift_tx serialiser.
// Defining SHIFT_TX_PARITY_EN adds the PARITY state encoding.
package shift_tx_pkg;

    localparam int unsigned DEFAULT_LOG_WIDTH = 3;

`ifdef SHIFT_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/shift_tx_if.sv
// Parallel-in / serial-out handshake bundle for shift_tx.
// master is the serialiser side, slave is its environment.
interface shift_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             tx_data;
    logic             tx_valid;
    logic             tx_last;
    logic             tx_ready;

    modport master (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid, tx_last
    );

    modport slave (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/shift_tx_cnt.sv
// Loadable down-counter that saturates at zero, with a zero flag.
module shift_tx_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);

    assign zero_c = (count == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero_c) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_tx.sv
// LSB-first parallel-to-serial transmitter with zero-gap back-to-back frames.
// Defining SHIFT_TX_PARITY_EN appends an even-parity bit to every frame.
module shift_tx
    import shift_tx_pkg::*;
#(
    parameter int unsigned LOG_WIDTH = DEFAULT_LOG_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    shift_tx_if.master bus
);

    localparam int unsigned WIDTH = 2 ** LOG_WIDTH;
    localparam int unsigned CNT_W = LOG_WIDTH + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             tx_data_nxt;
    logic             tx_valid_nxt;
    logic             tx_last_nxt;
    logic             in_ready_c;
    logic             accept;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;
`ifdef SHIFT_TX_PARITY_EN
    logic             parity;
    logic             parity_nxt;
`endif

    // Ready in IDLE or while the final frame bit is being consumed; forced low in reset.
    assign in_ready_c   = reset && ((state == IDLE) || (bus.tx_last && bus.tx_ready));
    assign bus.in_ready = in_ready_c;
    assign accept       = in_ready_c && bus.in_valid;

    shift_tx_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(WIDTH - 1)),
        .en       (cnt_en),
        .count    (cnt),
        .zero_c   (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.tx_ready && cnt_zero) begin
`ifdef SHIFT_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SHIFT_TX_PARITY_EN
            PARITY: begin
                if (bus.tx_ready) begin
                    state_nxt = accept ? SHIFT : IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered serial outputs and datapath controls.
    always_comb begin
        shreg_nxt    = shreg;
        tx_data_nxt  = bus.tx_data;
        tx_valid_nxt = bus.tx_valid;
        tx_last_nxt  = bus.tx_last;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
        parity_nxt   = parity;
`endif
        if (accept) begin
            shreg_nxt    = bus.in_data;
            tx_data_nxt  = bus.in_data[0];
            tx_valid_nxt = 1'b1;
            cnt_load     = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
            tx_last_nxt  = 1'b0;
            parity_nxt   = ^bus.in_data;
`else
            tx_last_nxt  = (WIDTH == 1);
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (bus.tx_ready) begin
                        if (!cnt_zero) begin
                            shreg_nxt   = shreg >> 1;
                            tx_data_nxt = shreg_nxt[0];
                            cnt_en      = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
                            tx_last_nxt = 1'b0;
`else
                            tx_last_nxt = (cnt == CNT_W'(1));
`endif
                        end else begin
`ifdef SHIFT_TX_PARITY_EN
                            tx_data_nxt  = parity;
                            tx_last_nxt  = 1'b1;
`else
                            tx_data_nxt  = 1'b0;
                            tx_valid_nxt = 1'b0;
                            tx_last_nxt  = 1'b0;
`endif
                        end
                    end
                end
`ifdef SHIFT_TX_PARITY_EN
                PARITY: begin
                    if (bus.tx_ready) begin
                        tx_data_nxt  = 1'b0;
                        tx_valid_nxt = 1'b0;
                        tx_last_nxt  = 1'b0;
                    end
                end
`endif
                default: begin
                    tx_data_nxt = bus.tx_data;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg        <= '0;
            bus.tx_data  <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_last  <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            shreg        <= shreg_nxt;
            bus.tx_data  <= tx_data_nxt;
            bus.tx_valid <= tx_valid_nxt;
            bus.tx_last  <= tx_last_nxt;
`ifdef SHIFT_TX_PARITY_EN
            parity       <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_shift_tx.sv
// Randomised bench for shift_tx against a queue-of-expected-bits frame model.
// Follows SHIFT_TX_PARITY_EN so the model matches the build under test.
module tb_shift_tx;

    localparam int unsigned LOG_WIDTH = 3;
    localparam int unsigned WIDTH     = 2 ** LOG_WIDTH;
`ifdef SHIFT_TX_PARITY_EN
    localparam int unsigned P_BITS = 1;
`else
    localparam int unsigned P_BITS = 0;
`endif
    localparam int unsigned FRAME = WIDTH + P_BITS;

    typedef struct {
        logic bit_v;
        logic last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    shift_tx_if #(.WIDTH(WIDTH)) bus ();

    shift_tx #(.LOG_WIDTH(LOG_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   valid_seen = 0;
    int   last_seen  = 0;
    bit   rnd_ready  = 1'b0;
    bit   busy;
    bit   exp_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A frame is the data word LSB first, then optionally its even parity.
    function automatic void push_frame(input logic [WIDTH-1:0] w);
        for (int i = 0; i < int'(WIDTH); i++) begin
            exp_q.push_back('{bit_v: w[i], last: (i == int'(WIDTH) - 1) && (P_BITS == 0)});
        end
        if (P_BITS != 0) begin
            exp_q.push_back('{bit_v: ^w, last: 1'b1});
        end
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
            check("rst_tx_data",  32'(bus.tx_data),  32'd0);
        end else begin
            busy    = (exp_q.size() != 0);
            exp_rdy = !busy || (bus.tx_ready && exp_q[0].last);
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("tx_valid", 32'(bus.tx_valid), 32'(busy));
            if (busy) begin
                check("tx_data", 32'(bus.tx_data), 32'(exp_q[0].bit_v));
                check("tx_last", 32'(bus.tx_last), 32'(exp_q[0].last));
                valid_seen++;
                if (bus.tx_ready) begin
                    if (exp_q[0].last) last_seen++;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && exp_rdy) begin
                push_frame(bus.in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_ready) bus.tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        bit acc;
        acc          = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            acc = bus.in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int l0;
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        bus.tx_ready = 1'b1;

        // Case 1: held in reset while a word is offered, then released.
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        idle(FRAME + 2);

        // Case 2: single frame, receiver always ready.
        v0 = valid_seen; l0 = last_seen;
        send_word(8'hA5);
        idle(FRAME + 2);
        check("c2_valid_cycles", 32'(valid_seen - v0), 32'(FRAME));
        check("c2_last_count",   32'(last_seen - l0),  32'd1);

        // Case 3: back-to-back frames with no gap.
        v0 = valid_seen; l0 = last_seen;
        send_word(8'h3C);
        send_word(8'hFF);
        idle(FRAME + 2);
        check("c3_valid_cycles", 32'(valid_seen - v0), 32'(2 * FRAME));
        check("c3_last_count",   32'(last_seen - l0),  32'd2);

        // Case 4: receiver stalls for three cycles on bit 0.
        v0 = valid_seen;
        send_word(8'h81);
        bus.tx_ready = 1'b0;
        idle(3);
        bus.tx_ready = 1'b1;
        idle(FRAME + 2);
        check("c4_valid_cycles", 32'(valid_seen - v0), 32'(FRAME + 3));

        // Case 5: parity of an even-weight and an odd-weight word.
        send_word(8'hA5);
        idle(FRAME + 2);
        send_word(8'h07);
        idle(FRAME + 2);

        // Case 6: reset mid-frame aborts, then a fresh frame starts from bit 0.
        l0 = last_seen;
        send_word(8'hF0);
        idle(3);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("c6_abort_valid", 32'(bus.tx_valid), 32'd0);
        tick();
        reset = 1'b1;
        send_word(8'h01);
        idle(FRAME + 2);
        check("c6_last_count", 32'(last_seen - l0), 32'd1);

        // Random words, random gaps, random receiver back-pressure.
        rnd_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send_word(WIDTH'($urandom));
            idle($urandom_range(0, 3));
        end
        rnd_ready    = 1'b0;
        bus.tx_ready = 1'b1;
        idle(2 * FRAME + 4);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
